wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Write-back arbiter between the in-order pipeline's WB stage, the long-latency execution unit (multi-cycle mul/div) and the register file write port.
- The register file has a single write port. The arbiter merges both result sources onto it:
  - the pipeline result always has priority;
  - long-latency results are held in a small FIFO until a free write slot appears.
- It reports pending destination registers to ID for interlocking, and raises a stall request to stop the FIFO starving.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- DEPTH, 2, long-latency result FIFO depth (power of two, ≥2)
- STARVE_LIMIT, 4, cycles a FIFO head may wait before stall_req asserts

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pipe_wen  in  1  pipeline WB write request this cycle
- pipe_waddr  in  ADDR_W  pipeline destination register
- pipe_wdata  in  DATA_W  pipeline result
- lu_valid  in  1  long-latency result offered
- lu_ready  out  1  FIFO can accept the offered result
- lu_waddr  in  ADDR_W  long-latency destination register
- lu_wdata  in  DATA_W  long-latency result
- rd1_addr  in  ADDR_W  ID rs address
- rd2_addr  in  ADDR_W  ID rt address
- rd1_pending  out  1  rs has an unwritten long-latency result
- rd2_pending  out  1  rt has an unwritten long-latency result
- stall_req  out  1  request that the pipeline insert a WB bubble
- wrn  out  1  register file write enable (registered)
- wrDataAddr  out  ADDR_W  register file write address (registered)
- wrData  out  DATA_W  register file write data (registered)
- buf_count  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset, synchronous, all flops:
  - wrn=0, wrDataAddr=0, wrData=0, buf_count=0;
  - FIFO pointers=0, starve counter=0.
  - While rst=1: lu_ready=0, rd1_pending=0, rd2_pending=0, stall_req=0.
  - Reset mid-operation discards all buffered entries. No write is issued.
- Pipeline-write definition: the pipeline is writing a cycle when pipe_wen=1 and pipe_waddr≠0. pipe_wen=1 with pipe_waddr=0 is ignored and leaves the slot free.
- Per-cycle selection (registered onto wrn/wrDataAddr/wrData at the next clk edge):
  - Pipeline writing: issue the pipeline write.
  - Otherwise, FIFO non-empty: pop the head and issue it.
  - Otherwise: wrn=0. wrDataAddr and wrData hold their previous values.
- Latency:
  - An accepted input appears on the write port 1 cycle after selection.
  - The register file commits it on the following edge.
  - During that gap the register file's own read bypass supplies the data.
- Handshake:
  - lu_ready = (buf_count < DEPTH), computed from registered count only.
  - A same-cycle pop does NOT raise ready.
  - Transfer occurs when lu_valid && lu_ready.
  - An accepted entry with lu_waddr=0 completes the handshake but is not enqueued.
- FIFO update:
  - Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
  - Push into an empty FIFO is not eligible for pop in the same cycle (no cut-through).
- Pending flags:
  - rdN_pending=1 when rdN_addr≠0 and either:
    - any valid FIFO entry has that address, or
    - the current cycle accepts an lu transfer with that address.
  - An entry being popped this cycle still counts as pending.
- Ordering:
  - ID uses the pending flags to ensure a pipeline write never targets a register held in the FIFO.
  - If this is violated, the pipeline write is issued first and the FIFO entry later (later one wins). The block does not check for it.
- Starvation:
  - starve_cnt increments each cycle the FIFO is non-empty and a pipeline write wins. It saturates at STARVE_LIMIT.
  - starve_cnt clears on any pop or when the FIFO is empty.
  - stall_req = (starve_cnt ≥ STARVE_LIMIT) or (buf_count == DEPTH and pipeline writing).
  - stall_req deasserts the cycle after the pop that relieves it.

Test Plan:
- Reset then idle → wrn=0, lu_ready=1, buf_count=0, pending flags 0.
- Pipe write r5=0x11 in cycle 0 → next cycle wrn=1, wrDataAddr=5, wrData=0x11. A pipe write to r0 produces wrn=0.
- lu result r8=0xAA pushed while the pipe writes r3 for 2 cycles:
  - rd1_addr=8 gives rd1_pending=1 throughout;
  - r3 is issued twice, then r8=0xAA;
  - buf_count returns to 0; pending clears the cycle after the pop.
- Fill FIFO (r9=1, r10=2) under continuous pipe writes:
  - lu_ready=0, stall_req=1;
  - one bubble → r9 issued; next bubble → r10; FIFO order is preserved.
- Continuous pipe writes with one FIFO entry → stall_req asserts after exactly 4 waiting cycles and drops after the pop.
- Mid-operation:
  - assert rst with buf_count=2 → next cycle buf_count=0, wrn=0, no stale write issued after release;
  - simultaneous push and pop at count=1 → count stays 1.

Source files
------------

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges pipeline WB results and buffered long-latency
// results onto the single register file write port, pipeline first.
module wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_wen,
  input  logic [ADDR_W-1:0]        pipe_waddr,
  input  logic [DATA_W-1:0]        pipe_wdata,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [ADDR_W-1:0]        lu_waddr,
  input  logic [DATA_W-1:0]        lu_wdata,
  input  logic [ADDR_W-1:0]        rd1_addr,
  input  logic [ADDR_W-1:0]        rd2_addr,
  output logic                     rd1_pending,
  output logic                     rd2_pending,
  output logic                     stall_req,
  output logic                     wrn,
  output logic [ADDR_W-1:0]        wrDataAddr,
  output logic [DATA_W-1:0]        wrData,
  output logic [$clog2(DEPTH):0]   buf_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [STV_W-1:0]  r_starve;
  logic              r_wrn;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic              w_pipe_write;
  logic              w_push;
  logic              w_pop;
  logic [DEPTH-1:0]  w_valid;
  logic              w_hit1;
  logic              w_hit2;

  // r0 writes never occupy the port; pop eligibility uses the registered
  // count so a fresh push cannot cut through in the same cycle.
  assign w_pipe_write = pipe_wen && (pipe_waddr != {ADDR_W{1'b0}});
  assign lu_ready     = !rst && (r_count < FULL_C);
  assign w_push       = lu_valid && lu_ready && (lu_waddr != {ADDR_W{1'b0}});
  assign w_pop        = !w_pipe_write && (r_count != {CNT_W{1'b0}});

  always_comb begin
    w_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = ({1'b0, PTR_W'(i) - r_rptr} < r_count);
    end
  end

  always_comb begin
    w_hit1 = w_push && (lu_waddr == rd1_addr);
    w_hit2 = w_push && (lu_waddr == rd2_addr);
    for (int i = 0; i < DEPTH; i++) begin
      w_hit1 = w_hit1 | (w_valid[i] && (r_mem_addr[i] == rd1_addr));
      w_hit2 = w_hit2 | (w_valid[i] && (r_mem_addr[i] == rd2_addr));
    end
  end

  assign rd1_pending = !rst && (rd1_addr != {ADDR_W{1'b0}}) && w_hit1;
  assign rd2_pending = !rst && (rd2_addr != {ADDR_W{1'b0}}) && w_hit2;
  assign stall_req   = !rst && ((r_starve >= LIMIT_C) || ((r_count == FULL_C) && w_pipe_write));

  assign wrn        = r_wrn;
  assign wrDataAddr = r_wr_addr;
  assign wrData     = r_wr_data;
  assign buf_count  = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrn     <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_starve  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_addr[i] <= '0;
        r_mem_data[i] <= '0;
      end
    end else begin
      if (w_pipe_write) begin
        r_wrn     <= 1'b1;
        r_wr_addr <= pipe_waddr;
        r_wr_data <= pipe_wdata;
      end else if (w_pop) begin
        r_wrn     <= 1'b1;
        r_wr_addr <= r_mem_addr[r_rptr];
        r_wr_data <= r_mem_data[r_rptr];
      end else begin
        r_wrn     <= 1'b0;
      end

      if (w_push) begin
        r_mem_addr[r_wptr] <= lu_waddr;
        r_mem_data[r_wptr] <= lu_wdata;
        r_wptr             <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      // A non-empty FIFO that did not pop lost the slot to the pipeline.
      if ((r_count == {CNT_W{1'b0}}) || w_pop) begin
        r_starve <= '0;
      end else if (r_starve < LIMIT_C) begin
        r_starve <= r_starve + STV_W'(1);
      end else begin
        r_starve <= r_starve;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed plus randomized bench for wb_arbiter, checked each cycle against a
// queue-based reference model of the write-back rules.
module tb_wb_arbiter;

  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 5;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  pipe_wen;
  logic [ADDR_W-1:0]     pipe_waddr;
  logic [DATA_W-1:0]     pipe_wdata;
  logic                  lu_valid;
  logic                  lu_ready;
  logic [ADDR_W-1:0]     lu_waddr;
  logic [DATA_W-1:0]     lu_wdata;
  logic [ADDR_W-1:0]     rd1_addr;
  logic [ADDR_W-1:0]     rd2_addr;
  logic                  rd1_pending;
  logic                  rd2_pending;
  logic                  stall_req;
  logic                  wrn;
  logic [ADDR_W-1:0]     wrDataAddr;
  logic [DATA_W-1:0]     wrData;
  logic [$clog2(DEPTH):0] buf_count;

  int checks   = 0;
  int failures = 0;

  logic [ADDR_W-1:0] q_addr [$];
  logic [DATA_W-1:0] q_data [$];
  int                m_starve;
  logic              m_wrn;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;

  wb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_wen(pipe_wen), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_pending(rd1_pending), .rd2_pending(rd2_pending),
    .stall_req(stall_req),
    .wrn(wrn), .wrDataAddr(wrDataAddr), .wrData(wrData),
    .buf_count(buf_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_pending(input logic [ADDR_W-1:0] a, input bit accept,
                                       input logic [ADDR_W-1:0] la);
    bit hit;
    hit = accept && (la == a);
    foreach (q_addr[i]) if (q_addr[i] == a) hit = 1'b1;
    return (a != '0) && hit;
  endfunction

  // One clock cycle: drive inputs, compare every output with the model, advance it.
  task automatic step(input bit r, input bit pw, input logic [ADDR_W-1:0] pa,
                      input logic [DATA_W-1:0] pd, input bit lv,
                      input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld,
                      input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
    int n;
    bit pipe_w, ready, accept, popped, exp_stall;
    @(negedge clk);
    rst = r; pipe_wen = pw; pipe_waddr = pa; pipe_wdata = pd;
    lu_valid = lv; lu_waddr = la; lu_wdata = ld; rd1_addr = a1; rd2_addr = a2;
    #1;
    n         = q_addr.size();
    pipe_w    = pw && (pa != '0);
    ready     = !r && (n < DEPTH);
    accept    = lv && ready;
    exp_stall = !r && ((m_starve >= STARVE_LIMIT) || ((n == DEPTH) && pipe_w));
    check("wrn", wrn, m_wrn);
    check("wrDataAddr", wrDataAddr, m_addr);
    check("wrData", wrData, m_data);
    check("buf_count", buf_count, n);
    check("lu_ready", lu_ready, ready);
    check("rd1_pending", rd1_pending, !r && model_pending(a1, accept, la));
    check("rd2_pending", rd2_pending, !r && model_pending(a2, accept, la));
    check("stall_req", stall_req, exp_stall);
    if (r) begin
      q_addr.delete(); q_data.delete();
      m_starve = 0; m_wrn = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      popped = 1'b0;
      if (pipe_w) begin
        m_wrn = 1'b1; m_addr = pa; m_data = pd;
      end else if (n > 0) begin
        m_wrn = 1'b1; m_addr = q_addr.pop_front(); m_data = q_data.pop_front();
        popped = 1'b1;
      end else begin
        m_wrn = 1'b0;
      end
      if (n == 0 || popped) m_starve = 0;
      else if (m_starve < STARVE_LIMIT) m_starve++;
      if (accept && la != '0) begin
        q_addr.push_back(la); q_data.push_back(ld);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [ADDR_W-1:0] a1);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a1, 5'd0);
  endtask

  initial begin
    rst = 1'b1; pipe_wen = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0; rd1_addr = '0; rd2_addr = '0;
    m_starve = 0; m_wrn = 1'b0; m_addr = '0; m_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd1_addr = 5'd1;
    #1;
    check("rst_wrn", wrn, 1'b0);
    check("rst_lu_ready", lu_ready, 1'b1);
    check("rst_buf_count", buf_count, 0);
    check("rst_rd1_pending", rd1_pending, 1'b0);
    check("rst_stall", stall_req, 1'b0);

    // Simple pipeline write and r0 suppression.
    step(1'b0, 1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("pw_wrn", wrn, 1'b1);
    check("pw_addr", wrDataAddr, 5'd5);
    check("pw_data", wrData, 32'h11);
    step(1'b0, 1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("r0_wrn", wrn, 1'b0);
    check("r0_addr_hold", wrDataAddr, 5'd5);

    // lu r8 held behind two pipeline writes to r3.
    step(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd8, 32'hAA, 5'd8, 5'd0);
    check("lu8_pend_a", rd1_pending, 1'b1);
    step(1'b0, 1'b1, 5'd3, 32'h34, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0);
    check("lu8_r3_addr", wrDataAddr, 5'd3);
    check("lu8_pend_b", rd1_pending, 1'b1);
    idle(5'd8);
    check("lu8_addr", wrDataAddr, 5'd8);
    check("lu8_data", wrData, 32'hAA);
    check("lu8_count", buf_count, 0);
    check("lu8_pend_clr", rd1_pending, 1'b0);

    // Fill the FIFO under pipeline pressure, then drain in order.
    step(1'b0, 1'b1, 5'd1, 32'h101, 1'b1, 5'd9, 32'd1, 5'd9, 5'd10);
    step(1'b0, 1'b1, 5'd2, 32'h102, 1'b1, 5'd10, 32'd2, 5'd9, 5'd10);
    check("full_count", buf_count, 2);
    check("full_ready", lu_ready, 1'b0);
    check("full_stall", stall_req, 1'b1);
    idle(5'd9);
    check("drain1_addr", wrDataAddr, 5'd9);
    check("drain1_data", wrData, 32'd1);
    idle(5'd10);
    check("drain2_addr", wrDataAddr, 5'd10);
    check("drain2_data", wrData, 32'd2);

    // Starvation: stall after exactly STARVE_LIMIT waiting cycles.
    step(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd7, 32'h77, 5'd0, 5'd0);
    for (int k = 1; k <= STARVE_LIMIT; k++) begin
      step(1'b0, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      check("starve_stall", stall_req, (k >= STARVE_LIMIT));
    end
    idle(5'd0);
    check("starve_pop_addr", wrDataAddr, 5'd7);
    check("starve_drop", stall_req, 1'b0);

    // Reset with a full FIFO discards everything.
    step(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd11, 32'hB, 5'd0, 5'd0);
    step(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd12, 32'hC, 5'd0, 5'd0);
    check("pre_rst_count", buf_count, 2);
    step(1'b1, 1'b1, 5'd6, 32'h6, 1'b0, 5'd0, 32'd0, 5'd11, 5'd12);
    check("mid_rst_count", buf_count, 0);
    check("mid_rst_wrn", wrn, 1'b0);
    idle(5'd11);
    check("post_rst_wrn_a", wrn, 1'b0);
    idle(5'd12);
    check("post_rst_wrn_b", wrn, 1'b0);

    // Simultaneous push and pop at count 1.
    step(1'b0, 1'b1, 5'd4, 32'h4, 1'b1, 5'd13, 32'hD, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'hE, 5'd0, 5'd0);
    check("pp_count", buf_count, 1);
    check("pp_addr", wrDataAddr, 5'd13);
    idle(5'd0);
    check("pp_next_addr", wrDataAddr, 5'd14);
    check("pp_next_data", wrData, 32'hE);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 63) == 0),
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
